multiword_add_seq: RTL

Sequencer that performs a WORDS×8-bit add or subtract by time-multiplexing one 8-bit ripple-carry adder slice over successive clock cycles. A registered carry links the slices. The block latches operands on a start handshake, processes one byte per cycle from LSB to MSB, and presents the result with carry-out and signed-overflow flags and a one-cycle done pulse. It sits between the control logic and the 8-bit adder datapath, allowing wide arithmetic without widening the adder.

---
 rtl/multiword_add_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - WORDS x 8-bit add/subtract sequencer sharing one 8-bit adder slice
module multiword_add_seq #(
  parameter int WORDS = 4,
  parameter int SLICE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [WORDS*SLICE-1:0] a,
  input  logic [WORDS*SLICE-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [WORDS*SLICE-1:0] sum,
  output logic                   cout,
  output logic                   ovf
);
  localparam int            W        = WORDS * SLICE;
  localparam int            IW       = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic            r_busy;
  logic            r_done;
  logic            r_cout;
  logic            r_ovf;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE:0]   w_res;

  // Select the operand bytes for the slice currently being processed.
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_slice = r_a[k*SLICE +: SLICE];
        w_b_slice = r_b[k*SLICE +: SLICE];
      end
    end
  end

  assign w_res = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE{1'b0}}, r_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B once here and force carry-in.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IW'(k)) r_sum[k*SLICE +: SLICE] <= w_res[SLICE-1:0];
          end
          r_carry <= w_res[SLICE];
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_res[SLICE];
            r_ovf   <= (w_a_slice[SLICE-1] == w_b_slice[SLICE-1]) &&
                       (w_res[SLICE-1] != w_a_slice[SLICE-1]);
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
